// File: rtl/addr_mode_seq.sv
// Sequenced addressing-mode unit: decodes MOV/MVI/LDA, fetches the immediate word and the
// memory operand as needed, then issues a single register-file write.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// S_IDLE      | ready for a new instruction
// S_FETCH_IMM | requesting the next instruction word (imm_req)
// S_MEM_REQ   | one-cycle memory read strobe at the captured address
// S_MEM_WAIT  | waiting for mem_rvalid
// S_WB        | register-file write strobe, done
// S_ERR       | one-cycle error pulse with err_code
module addr_mode_seq #(
    parameter int DATA_W   = 16,
    parameter int REG_AW   = 3,
    parameter int MEM_AW   = 16,
    parameter int ACC_ADDR = 0,
    parameter int TIMEOUT  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              ready,
    input  logic [3:0]        opcode,
    input  logic [REG_AW-1:0] op1_regaddr,
    input  logic [DATA_W-1:0] op2_data,
    output logic              imm_req,
    input  logic              imm_valid,
    input  logic [DATA_W-1:0] imm_word,
    output logic              mem_rd_en,
    output logic [MEM_AW-1:0] mem_addr,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              flush,
    output logic              wb_en,
    output logic [REG_AW-1:0] wb_addr,
    output logic [DATA_W-1:0] wb_data,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code
);

    localparam logic [3:0] OP_MOV = 4'b1011;
    localparam logic [3:0] OP_MVI = 4'b1100;
    localparam logic [3:0] OP_LDA = 4'b1101;

    localparam bit TO_EN = (TIMEOUT != 0);
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH_IMM,
        S_MEM_REQ,
        S_MEM_WAIT,
        S_WB,
        S_ERR
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [3:0]        op_q, op_d;
    logic [REG_AW-1:0] dst_q, dst_d;
    logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
    logic [REG_AW-1:0] wb_addr_q, wb_addr_d;
    logic [DATA_W-1:0] wb_data_q, wb_data_d;
    logic [1:0]        err_code_q, err_code_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            op_q       <= '0;
            dst_q      <= '0;
            mem_addr_q <= '0;
            wb_addr_q  <= '0;
            wb_data_q  <= '0;
            err_code_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            dst_q      <= dst_d;
            mem_addr_q <= mem_addr_d;
            wb_addr_q  <= wb_addr_d;
            wb_data_q  <= wb_data_d;
            err_code_q <= err_code_d;
        end
    end

    // cnt_q counts down from CNT_LOAD; reaching zero without a valid is the timeout
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        dst_d      = dst_q;
        mem_addr_d = mem_addr_q;
        wb_addr_d  = wb_addr_q;
        wb_data_d  = wb_data_q;
        err_code_d = err_code_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d  = opcode;
                    dst_d = op1_regaddr;
                    case (opcode)
                        OP_MOV: begin
                            state_d   = S_WB;
                            wb_addr_d = op1_regaddr;
                            wb_data_d = op2_data;
                        end
                        OP_MVI, OP_LDA: begin
                            state_d = S_FETCH_IMM;
                            cnt_d   = CNT_LOAD;
                        end
                        default: begin
                            state_d    = S_ERR;
                            err_code_d = 2'b01;
                        end
                    endcase
                end
            end
            S_FETCH_IMM: begin
                if (imm_valid) begin
                    if (op_q == OP_MVI) begin
                        state_d   = S_WB;
                        wb_addr_d = dst_q;
                        wb_data_d = imm_word;
                    end else begin
                        state_d    = S_MEM_REQ;
                        mem_addr_d = imm_word[MEM_AW-1:0];
                    end
                end else if (TO_EN && (cnt_q == '0)) begin
                    state_d    = S_ERR;
                    err_code_d = 2'b10;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_MEM_REQ: begin
                state_d = S_MEM_WAIT;
                cnt_d   = CNT_LOAD;
            end
            S_MEM_WAIT: begin
                if (mem_rvalid) begin
                    state_d   = S_WB;
                    wb_addr_d = REG_AW'(ACC_ADDR);
                    wb_data_d = mem_rdata;
                end else if (TO_EN && (cnt_q == '0)) begin
                    state_d    = S_ERR;
                    err_code_d = 2'b11;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_WB:    state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // flush wins over everything, including a start seen in IDLE
        if (flush) begin
            state_d    = S_IDLE;
            cnt_d      = cnt_q;
            op_d       = op_q;
            dst_d      = dst_q;
            mem_addr_d = mem_addr_q;
            wb_addr_d  = wb_addr_q;
            wb_data_d  = wb_data_q;
            err_code_d = err_code_q;
        end
    end

    assign ready     = (state_q == S_IDLE);
    assign imm_req   = (state_q == S_FETCH_IMM);
    assign mem_rd_en = (state_q == S_MEM_REQ);
    assign wb_en     = (state_q == S_WB);
    assign done      = (state_q == S_WB);
    assign err       = (state_q == S_ERR);
    assign mem_addr  = mem_addr_q;
    assign wb_addr   = wb_addr_q;
    assign wb_data   = wb_data_q;
    assign err_code  = err_code_q;

endmodule

// File: tb/tb_addr_mode_seq.sv
// Directed bench for addr_mode_seq (TIMEOUT=4): MOV/MVI/LDA flows, illegal opcode,
// imm and mem timeouts, flush and asynchronous reset mid-instruction.
module tb_addr_mode_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        ready;
    logic [3:0]  opcode;
    logic [2:0]  op1_regaddr;
    logic [15:0] op2_data;
    logic        imm_req;
    logic        imm_valid;
    logic [15:0] imm_word;
    logic        mem_rd_en;
    logic [15:0] mem_addr;
    logic        mem_rvalid;
    logic [15:0] mem_rdata;
    logic        flush;
    logic        wb_en;
    logic [2:0]  wb_addr;
    logic [15:0] wb_data;
    logic        done;
    logic        err;
    logic [1:0]  err_code;

    int checks = 0;
    int errors = 0;

    addr_mode_seq #(
        .DATA_W(16), .REG_AW(3), .MEM_AW(16), .ACC_ADDR(0), .TIMEOUT(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .ready(ready), .opcode(opcode),
        .op1_regaddr(op1_regaddr), .op2_data(op2_data), .imm_req(imm_req),
        .imm_valid(imm_valid), .imm_word(imm_word), .mem_rd_en(mem_rd_en),
        .mem_addr(mem_addr), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .flush(flush), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .done(done), .err(err), .err_code(err_code)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // control vector = {ready, imm_req, mem_rd_en, wb_en, done, err}
    task automatic chk_ctrl(input string tag, input logic [5:0] exp);
        chk(tag, 32'({ready, imm_req, mem_rd_en, wb_en, done, err}), 32'(exp));
    endtask

    task automatic chk_reset_vals(input string tag);
        chk_ctrl({tag, "_ctrl"}, 6'b100000);
        chk({tag, "_mem_addr"}, 32'(mem_addr), 32'h0);
        chk({tag, "_wb_addr"}, 32'(wb_addr), 32'h0);
        chk({tag, "_wb_data"}, 32'(wb_data), 32'h0);
        chk({tag, "_err_code"}, 32'(err_code), 32'h0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; opcode = 4'h0; op1_regaddr = 3'd0; op2_data = 16'h0;
        imm_valid = 1'b0; imm_word = 16'h0; mem_rvalid = 1'b0; mem_rdata = 16'h0;
        flush = 1'b0;

        #12;
        chk_reset_vals("reset");
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk_ctrl("idle_after_reset", 6'b100000);

        // 1: MOV, then a second MOV back-to-back at the 1-per-2 rate
        start = 1'b1; opcode = 4'b1011; op1_regaddr = 3'd3; op2_data = 16'hBEEF;
        tick();
        start = 1'b0;
        chk_ctrl("mov_wb_ctrl", 6'b000110);
        chk("mov_wb_addr", 32'(wb_addr), 32'd3);
        chk("mov_wb_data", 32'(wb_data), 32'hBEEF);
        tick();
        chk_ctrl("mov_ready_after", 6'b100000);
        start = 1'b1; op1_regaddr = 3'd6; op2_data = 16'h0102;
        tick();
        start = 1'b0;
        chk_ctrl("mov2_wb_ctrl", 6'b000110);
        chk("mov2_wb_data", 32'(wb_data), 32'h0102);
        tick();

        // 2: MVI, imm_valid two cycles after imm_req; start during busy is ignored
        start = 1'b1; opcode = 4'b1100; op1_regaddr = 3'd5; op2_data = 16'h0;
        tick();
        chk_ctrl("mvi_fetch1", 6'b010000);
        opcode = 4'b1011; op1_regaddr = 3'd7; op2_data = 16'hDEAD;
        tick();
        chk_ctrl("mvi_fetch2", 6'b010000);
        tick();
        chk_ctrl("mvi_fetch3", 6'b010000);
        start = 1'b0; imm_valid = 1'b1; imm_word = 16'h1234;
        tick();
        imm_valid = 1'b0;
        chk_ctrl("mvi_wb_ctrl", 6'b000110);
        chk("mvi_wb_addr", 32'(wb_addr), 32'd5);
        chk("mvi_wb_data", 32'(wb_data), 32'h1234);
        tick();
        chk_ctrl("mvi_idle", 6'b100000);

        // 3: LDA, mem_rvalid in MEM_REQ ignored, real data 3 cycles after mem_rd_en
        start = 1'b1; opcode = 4'b1101; op1_regaddr = 3'd2;
        tick();
        start = 1'b0;
        chk_ctrl("lda_fetch", 6'b010000);
        imm_valid = 1'b1; imm_word = 16'h00A0;
        tick();
        imm_valid = 1'b0;
        chk_ctrl("lda_mem_req", 6'b001000);
        chk("lda_mem_addr", 32'(mem_addr), 32'h00A0);
        mem_rvalid = 1'b1; mem_rdata = 16'hFFFF;
        tick();
        mem_rvalid = 1'b0;
        chk_ctrl("lda_wait1", 6'b000000);
        tick();
        chk_ctrl("lda_wait2", 6'b000000);
        tick();
        chk_ctrl("lda_wait3", 6'b000000);
        mem_rvalid = 1'b1; mem_rdata = 16'h5A5A;
        tick();
        mem_rvalid = 1'b0;
        chk_ctrl("lda_wb_ctrl", 6'b000110);
        chk("lda_wb_addr", 32'(wb_addr), 32'd0);
        chk("lda_wb_data", 32'(wb_data), 32'h5A5A);
        tick();

        // 4: illegal opcode
        start = 1'b1; opcode = 4'b0000;
        tick();
        start = 1'b0;
        chk_ctrl("ill_err_ctrl", 6'b000001);
        chk("ill_err_code", 32'(err_code), 32'h1);
        tick();
        chk_ctrl("ill_idle", 6'b100000);

        // 5a: LDA with mem_rvalid withheld -> mem timeout after 4 wait cycles
        start = 1'b1; opcode = 4'b1101;
        tick();
        start = 1'b0; imm_valid = 1'b1; imm_word = 16'h0042;
        tick();
        imm_valid = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk_ctrl($sformatf("mto_wait%0d", i), 6'b000000);
        end
        tick();
        chk_ctrl("mto_err_ctrl", 6'b000001);
        chk("mto_err_code", 32'(err_code), 32'h3);
        tick();

        // 5b: mem_rvalid on the 4th wait cycle wins over the timeout
        start = 1'b1; opcode = 4'b1101;
        tick();
        start = 1'b0; imm_valid = 1'b1; imm_word = 16'h0042;
        tick();
        imm_valid = 1'b0;
        tick(); tick(); tick(); tick();
        mem_rvalid = 1'b1; mem_rdata = 16'h7777;
        tick();
        mem_rvalid = 1'b0;
        chk_ctrl("mlast_wb_ctrl", 6'b000110);
        chk("mlast_wb_data", 32'(wb_data), 32'h7777);
        tick();

        // 5c: MVI with imm_valid withheld -> imm timeout
        start = 1'b1; opcode = 4'b1100; op1_regaddr = 3'd1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        chk_ctrl("ito_fetch4", 6'b010000);
        tick();
        chk_ctrl("ito_err_ctrl", 6'b000001);
        chk("ito_err_code", 32'(err_code), 32'h2);
        tick();

        // 6a: flush in MEM_WAIT, then a late mem_rvalid
        start = 1'b1; opcode = 4'b1101;
        tick();
        start = 1'b0; imm_valid = 1'b1; imm_word = 16'h0010;
        tick();
        imm_valid = 1'b0;
        tick();
        chk_ctrl("fl_wait1", 6'b000000);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk_ctrl("fl_idle", 6'b100000);
        mem_rvalid = 1'b1; mem_rdata = 16'h9999;
        tick();
        mem_rvalid = 1'b0;
        chk_ctrl("fl_late_rvalid", 6'b100000);
        chk("fl_wb_data_held", 32'(wb_data), 32'h7777);

        // 6b: flush together with start in IDLE
        start = 1'b1; opcode = 4'b1011; op1_regaddr = 3'd4; op2_data = 16'hAAAA; flush = 1'b1;
        tick();
        start = 1'b0; flush = 1'b0;
        chk_ctrl("fl_start_ignored", 6'b100000);
        tick();
        chk_ctrl("fl_start_still_idle", 6'b100000);

        // 6c: asynchronous reset mid-MVI, then a normal MOV
        start = 1'b1; opcode = 4'b1100; op1_regaddr = 3'd4;
        tick();
        start = 1'b0;
        chk_ctrl("rst_mvi_fetch", 6'b010000);
        #2 rst_n = 1'b0;
        #1;
        chk_reset_vals("midrst");
        imm_valid = 1'b1; imm_word = 16'h4444;
        @(negedge clk);
        rst_n = 1'b1; imm_valid = 1'b0;
        tick();
        chk_ctrl("postrst_idle", 6'b100000);
        start = 1'b1; opcode = 4'b1011; op1_regaddr = 3'd1; op2_data = 16'h0F0F;
        tick();
        start = 1'b0;
        chk_ctrl("postrst_mov_ctrl", 6'b000110);
        chk("postrst_mov_addr", 32'(wb_addr), 32'd1);
        chk("postrst_mov_data", 32'(wb_data), 32'h0F0F);
        tick();
        chk_ctrl("postrst_idle2", 6'b100000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
